axi_line_master: RTL and testbench
==================================

AXI_LINE_MASTER -- requirements
Module: axi_line_master

Interface
REQ-001 Parameter WIDTH_AD, default 32: AXI address width.
REQ-002 Parameter WIDTH_DA, default 32: AXI data beat width; power of two, 8..128.
REQ-003 Parameter LINE_W, default 128: cache-line width; integer multiple of WIDTH_DA; BEATS = LINE_W/WIDTH_DA, range 1..16.
REQ-004 M_AXI_ACLK  in  1  sole clock; all logic on rising edge.
REQ-005 M_AXI_ARESETN  in  1  reset, synchronous, active-low.
REQ-006 req_valid  in  1  core line request valid.
REQ-007 req_ready  out  1  block can accept a request.
REQ-008 req_rw  in  1  1 = read line, 0 = write line.
REQ-009 req_addr  in  WIDTH_AD  byte address; low log2(LINE_W/8) bits ignored.
REQ-010 req_wdata  in  LINE_W  write line; beat k = bits [k*WIDTH_DA +: WIDTH_DA].
REQ-011 rsp_rdata  out  LINE_W  assembled read line; same beat mapping.
REQ-012 rsp_rd_done / rsp_wr_done  out  1 each  one-cycle completion pulses.
REQ-013 rsp_err  out  1  error flag, valid in the done-pulse cycle.
REQ-014 AW channel: M_AXI_AWADDR out WIDTH_AD, AWLEN out 4, AWSIZE out 3, AWBURST out 2, AWVALID out 1, AWREADY in 1.
REQ-015 W channel: M_AXI_WDATA out WIDTH_DA, WSTRB out WIDTH_DA/8, WLAST out 1, WVALID out 1, WREADY in 1.
REQ-016 B channel: M_AXI_BRESP in 2, BVALID in 1, BREADY out 1.
REQ-017 AR channel: M_AXI_ARADDR out WIDTH_AD, ARLEN out 4, ARSIZE out 3, ARBURST out 2, ARVALID out 1, ARREADY in 1.
REQ-018 R channel: M_AXI_RDATA in WIDTH_DA, RRESP in 2, RLAST in 1, RVALID in 1, RREADY out 1.

Function
REQ-019 Single FSM, states IDLE, RADDR, RDATA, WADDR, WDATA, WRESP; one transaction outstanding at a time.
REQ-020 req_ready = 1 only in IDLE; accept on req_valid&&req_ready; capture line-aligned addr, req_wdata, strobes; req_* ignored outside an accept.
REQ-021 Accept read -> RADDR, accept write -> WADDR; ARVALID/AWVALID high from the next cycle, held with stable address until READY sampled high.
REQ-022 AxLEN = BEATS-1, AxSIZE = log2(WIDTH_DA/8), AxBURST = 2'b01 INCR, constant.
REQ-023 AW handshake -> WDATA; WVALID high from next cycle; beat counter advances only on WVALID&&WREADY; WLAST high exactly on beat BEATS-1; last handshake -> WRESP.
REQ-024 BREADY = 1 only in WRESP; on BVALID -> IDLE, rsp_wr_done pulses next cycle, rsp_err = BRESP[1].
REQ-025 AR handshake -> RDATA; RREADY = 1 only in RDATA; each beat written to its slice of rsp_rdata.
REQ-026 Read ends on the beat where counter = BEATS-1 or RLAST = 1, whichever first -> IDLE; rsp_rd_done pulses next cycle.
REQ-027 Read rsp_err = OR of RRESP[1] over all beats, or RLAST mismatched with counter (early, or missing on beat BEATS-1).
REQ-028 rsp_rdata holds until the next read's beats overwrite it; unaffected by writes.
REQ-029 Done pulse coincides with req_ready = 1; a request presented in that cycle is accepted.
REQ-030 BEATS = 1: single beat, WLAST on that beat, AxLEN = 0.

Reset
REQ-031 ARESETN low at an edge: FSM -> IDLE, all VALID/READY outputs, WLAST, done pulses, rsp_err, counter -> 0, rsp_rdata -> 0, addresses -> 0; any in-flight burst abandoned without a done pulse.
REQ-032 req_ready = 1 in the first cycle after reset release.

Configuration
REQ-033 AXI_M_WSTRB_EN defined: input req_wstrb (LINE_W/8) exists; beat k WSTRB = req_wstrb[k*WIDTH_DA/8 +: WIDTH_DA/8], captured at accept.
REQ-034 AXI_M_WSTRB_EN undefined: req_wstrb absent; WSTRB all ones on every beat.

Verification
REQ-035 Read 0x1000_0004, defaults, slave returns 0x11,0x22,0x33,0x44 with RLAST on beat 3 -> ARADDR 0x1000_0000, ARLEN 3, rsp_rdata 0x00000044_00000033_00000022_00000011, one rd_done pulse, rsp_err 0.
REQ-036 Write 0xAABBCCDD_11223344_55667788_99AABBCC, WREADY toggling every cycle -> W beats 0x99AABBCC, 0x55667788, 0x11223344, 0xAABBCCDD, WLAST only on the 4th, wr_done after BVALID, err 0.
REQ-037 Write with BRESP 2'b10 -> rsp_wr_done with rsp_err 1; read with RLAST on beat 1 -> rd_done after beat 1, rsp_err 1.
REQ-038 Reset asserted in RDATA after beat 1 -> all outputs at reset values next cycle, no done pulse, then a new read completes normally.
REQ-039 AXI_M_WSTRB_EN on, req_wstrb 16'h00F0 -> WSTRB 0x0,0xF,0x0,0x0; off -> 0xF on all beats.

Source files
------------

// File: rtl/axi_line_master_if.sv
// AXI4 channel bundle for axi_line_master: the master modport drives AW/W/AR and the
// B/R ready signals, the slave modport drives the responses.
interface axi_line_master_if #(
  parameter int WIDTH_AD = 32,
  parameter int WIDTH_DA = 32
);
  logic [WIDTH_AD-1:0]   M_AXI_AWADDR;
  logic [3:0]            M_AXI_AWLEN;
  logic [2:0]            M_AXI_AWSIZE;
  logic [1:0]            M_AXI_AWBURST;
  logic                  M_AXI_AWVALID;
  logic                  M_AXI_AWREADY;
  logic [WIDTH_DA-1:0]   M_AXI_WDATA;
  logic [WIDTH_DA/8-1:0] M_AXI_WSTRB;
  logic                  M_AXI_WLAST;
  logic                  M_AXI_WVALID;
  logic                  M_AXI_WREADY;
  logic [1:0]            M_AXI_BRESP;
  logic                  M_AXI_BVALID;
  logic                  M_AXI_BREADY;
  logic [WIDTH_AD-1:0]   M_AXI_ARADDR;
  logic [3:0]            M_AXI_ARLEN;
  logic [2:0]            M_AXI_ARSIZE;
  logic [1:0]            M_AXI_ARBURST;
  logic                  M_AXI_ARVALID;
  logic                  M_AXI_ARREADY;
  logic [WIDTH_DA-1:0]   M_AXI_RDATA;
  logic [1:0]            M_AXI_RRESP;
  logic                  M_AXI_RLAST;
  logic                  M_AXI_RVALID;
  logic                  M_AXI_RREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWVALID,
    input  M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
    input  M_AXI_WREADY,
    input  M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_BREADY,
    output M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARVALID,
    input  M_AXI_ARREADY,
    input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID,
    output M_AXI_RREADY
  );

  modport slave (
    input  M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWVALID,
    output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
    output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_BREADY,
    input  M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARVALID,
    output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID,
    input  M_AXI_RREADY
  );
endinterface

// File: rtl/axi_line_master.sv
// Line-granular AXI4 master: moves one LINE_W-bit line per INCR burst, one transaction at a time.
// Define AXI_M_WSTRB_EN to add the req_wstrb input for per-byte write strobes.
module axi_line_master #(
  parameter int WIDTH_AD = 32,
  parameter int WIDTH_DA = 32,
  parameter int LINE_W   = 128
) (
  input  logic                M_AXI_ACLK,
  input  logic                M_AXI_ARESETN,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_rw,
  input  logic [WIDTH_AD-1:0] req_addr,
  input  logic [LINE_W-1:0]   req_wdata,
`ifdef AXI_M_WSTRB_EN
  input  logic [LINE_W/8-1:0] req_wstrb,
`endif
  output logic [LINE_W-1:0]   rsp_rdata,
  output logic                rsp_rd_done,
  output logic                rsp_wr_done,
  output logic                rsp_err,
  axi_line_master_if.master   m_axi
);

  localparam int BEATS = LINE_W / WIDTH_DA;
  localparam int BW    = WIDTH_DA / 8;
  localparam int OFF   = $clog2(LINE_W / 8);
  localparam logic [3:0]          LAST_BEAT  = 4'(BEATS - 1);
  localparam logic [WIDTH_AD-1:0] ALIGN_MASK = {WIDTH_AD{1'b1}} << OFF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RADDR = 3'd1,
    RDATA = 3'd2,
    WADDR = 3'd3,
    WDATA = 3'd4,
    WRESP = 3'd5
  } state_t;

  state_t              state_r, next_state_s;
  logic [3:0]          cnt_r, next_cnt_s;
  logic                req_ready_r, arvalid_r, awvalid_r, wvalid_r, wlast_r, bready_r, rready_r;
  logic [WIDTH_AD-1:0] araddr_r, awaddr_r;
  logic [LINE_W-1:0]   wdata_r, rdata_r;
  logic [WIDTH_DA-1:0] wdata_out_r;
  logic                rd_done_r, wr_done_r, rsp_err_r, rd_err_acc_r;
  logic                accept_s, ar_hs_s, aw_hs_s, w_hs_s, b_hs_s, r_hs_s;
  logic                rd_last_s, beat_err_s;

  assign accept_s   = req_valid & req_ready_r;
  assign ar_hs_s    = arvalid_r & m_axi.M_AXI_ARREADY;
  assign aw_hs_s    = awvalid_r & m_axi.M_AXI_AWREADY;
  assign w_hs_s     = wvalid_r & m_axi.M_AXI_WREADY;
  assign b_hs_s     = bready_r & m_axi.M_AXI_BVALID;
  assign r_hs_s     = rready_r & m_axi.M_AXI_RVALID;
  // A read burst ends on the expected final beat or on an early RLAST; a mismatch is an error.
  assign rd_last_s  = (cnt_r == LAST_BEAT) | m_axi.M_AXI_RLAST;
  assign beat_err_s = (m_axi.M_AXI_RRESP >= 2'b10) | (m_axi.M_AXI_RLAST != (cnt_r == LAST_BEAT));

  // Next-state and next beat-count decode
  always_comb begin
    next_state_s = state_r;
    next_cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        next_cnt_s = 4'd0;
        if (accept_s) begin
          next_state_s = req_rw ? RADDR : WADDR;
        end else begin
          next_state_s = IDLE;
        end
      end
      RADDR: begin
        if (ar_hs_s) begin
          next_state_s = RDATA;
        end else begin
          next_state_s = RADDR;
        end
      end
      RDATA: begin
        if (r_hs_s && rd_last_s) begin
          next_state_s = IDLE;
          next_cnt_s   = 4'd0;
        end else if (r_hs_s) begin
          next_state_s = RDATA;
          next_cnt_s   = cnt_r + 4'd1;
        end else begin
          next_state_s = RDATA;
          next_cnt_s   = cnt_r;
        end
      end
      WADDR: begin
        if (aw_hs_s) begin
          next_state_s = WDATA;
        end else begin
          next_state_s = WADDR;
        end
      end
      WDATA: begin
        if (w_hs_s && (cnt_r == LAST_BEAT)) begin
          next_state_s = WRESP;
          next_cnt_s   = 4'd0;
        end else if (w_hs_s) begin
          next_state_s = WDATA;
          next_cnt_s   = cnt_r + 4'd1;
        end else begin
          next_state_s = WDATA;
          next_cnt_s   = cnt_r;
        end
      end
      WRESP: begin
        if (b_hs_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = WRESP;
        end
      end
      default: begin
        next_state_s = IDLE;
        next_cnt_s   = 4'd0;
      end
    endcase
  end

  // FSM state, beat counter and handshake outputs, registered from the next state
  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      req_ready_r <= 1'b1;
      arvalid_r   <= 1'b0;
      awvalid_r   <= 1'b0;
      wvalid_r    <= 1'b0;
      wlast_r     <= 1'b0;
      bready_r    <= 1'b0;
      rready_r    <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      cnt_r       <= next_cnt_s;
      req_ready_r <= (next_state_s == IDLE);
      arvalid_r   <= (next_state_s == RADDR);
      awvalid_r   <= (next_state_s == WADDR);
      wvalid_r    <= (next_state_s == WDATA);
      wlast_r     <= (next_state_s == WDATA) && (next_cnt_s == LAST_BEAT);
      bready_r    <= (next_state_s == WRESP);
      rready_r    <= (next_state_s == RDATA);
    end
  end

  // Request capture, read-line assembly and completion reporting
  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      araddr_r     <= '0;
      awaddr_r     <= '0;
      wdata_r      <= '0;
      wdata_out_r  <= '0;
      rdata_r      <= '0;
      rd_err_acc_r <= 1'b0;
      rd_done_r    <= 1'b0;
      wr_done_r    <= 1'b0;
      rsp_err_r    <= 1'b0;
    end else begin
      if (accept_s && req_rw) begin
        araddr_r <= req_addr & ALIGN_MASK;
      end
      if (accept_s && !req_rw) begin
        awaddr_r <= req_addr & ALIGN_MASK;
        wdata_r  <= req_wdata;
      end
      wdata_out_r <= wdata_r[next_cnt_s*WIDTH_DA +: WIDTH_DA];
      if (r_hs_s) begin
        rdata_r[cnt_r*WIDTH_DA +: WIDTH_DA] <= m_axi.M_AXI_RDATA;
      end
      if (accept_s) begin
        rd_err_acc_r <= 1'b0;
      end else if (r_hs_s) begin
        rd_err_acc_r <= rd_err_acc_r | beat_err_s;
      end
      rd_done_r <= r_hs_s & rd_last_s;
      wr_done_r <= b_hs_s;
      if (r_hs_s && rd_last_s) begin
        rsp_err_r <= rd_err_acc_r | beat_err_s;
      end else if (b_hs_s) begin
        rsp_err_r <= (m_axi.M_AXI_BRESP >= 2'b10);
      end else begin
        rsp_err_r <= 1'b0;
      end
    end
  end

`ifdef AXI_M_WSTRB_EN
  logic [LINE_W/8-1:0] wstrb_r;
  logic [BW-1:0]       wstrb_out_r;

  // Byte strobes follow the same beat slicing as the write data
  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      wstrb_r     <= '0;
      wstrb_out_r <= '0;
    end else begin
      if (accept_s && !req_rw) begin
        wstrb_r <= req_wstrb;
      end
      wstrb_out_r <= wstrb_r[next_cnt_s*BW +: BW];
    end
  end

  assign m_axi.M_AXI_WSTRB = wstrb_out_r;
`else
  assign m_axi.M_AXI_WSTRB = {BW{1'b1}};
`endif

  assign req_ready     = req_ready_r;
  assign rsp_rdata     = rdata_r;
  assign rsp_rd_done   = rd_done_r;
  assign rsp_wr_done   = wr_done_r;
  assign rsp_err       = rsp_err_r;

  assign m_axi.M_AXI_AWADDR  = awaddr_r;
  assign m_axi.M_AXI_AWLEN   = LAST_BEAT;
  assign m_axi.M_AXI_AWSIZE  = 3'($clog2(BW));
  assign m_axi.M_AXI_AWBURST = 2'b01;
  assign m_axi.M_AXI_AWVALID = awvalid_r;
  assign m_axi.M_AXI_WDATA   = wdata_out_r;
  assign m_axi.M_AXI_WLAST   = wlast_r;
  assign m_axi.M_AXI_WVALID  = wvalid_r;
  assign m_axi.M_AXI_BREADY  = bready_r;
  assign m_axi.M_AXI_ARADDR  = araddr_r;
  assign m_axi.M_AXI_ARLEN   = LAST_BEAT;
  assign m_axi.M_AXI_ARSIZE  = 3'($clog2(BW));
  assign m_axi.M_AXI_ARBURST = 2'b01;
  assign m_axi.M_AXI_ARVALID = arvalid_r;
  assign m_axi.M_AXI_RREADY  = rready_r;

endmodule

// File: tb/tb_axi_line_master.sv
// Directed self-checking bench for axi_line_master with default parameters; the bench
// plays the AXI slave by hand, cycle by cycle.
module tb_axi_line_master;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic         req_rw;
  logic [31:0]  req_addr;
  logic [127:0] req_wdata;
`ifdef AXI_M_WSTRB_EN
  logic [15:0]  req_wstrb;
`endif
  logic [127:0] rsp_rdata;
  logic         rsp_rd_done;
  logic         rsp_wr_done;
  logic         rsp_err;

  int checks = 0;
  int errors = 0;
  int idx;

  logic [31:0] exp_w [4] = '{32'h99AABBCC, 32'h55667788, 32'h11223344, 32'hAABBCCDD};
`ifdef AXI_M_WSTRB_EN
  logic [3:0]  exp_s [4] = '{4'h0, 4'hF, 4'h0, 4'h0};
`else
  logic [3:0]  exp_s [4] = '{4'hF, 4'hF, 4'hF, 4'hF};
`endif

  always #5 clk = ~clk;

  axi_line_master_if #(.WIDTH_AD(32), .WIDTH_DA(32)) bus ();

  axi_line_master #(.WIDTH_AD(32), .WIDTH_DA(32), .LINE_W(128)) dut (
    .M_AXI_ACLK    (clk),
    .M_AXI_ARESETN (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_rw        (req_rw),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
`ifdef AXI_M_WSTRB_EN
    .req_wstrb     (req_wstrb),
`endif
    .rsp_rdata     (rsp_rdata),
    .rsp_rd_done   (rsp_rd_done),
    .rsp_wr_done   (rsp_wr_done),
    .rsp_err       (rsp_err),
    .m_axi         (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_req(input logic rw, input logic [31:0] addr, input logic [127:0] wdata);
    req_valid = 1'b1;
    req_rw    = rw;
    req_addr  = addr;
    req_wdata = wdata;
    tick();
    req_valid = 1'b0;
  endtask

  // AR handshake, then beats d0*(k+1); RLAST on beat rlast_at (-1: never), RRESP=SLVERR on beat err_at
  task automatic rd_burst(input logic [31:0] d0, input int rlast_at, input int err_at);
    int nb;
    nb = (rlast_at >= 0 && rlast_at < 3) ? rlast_at + 1 : 4;
    bus.M_AXI_ARREADY = 1'b1;
    tick();
    bus.M_AXI_ARREADY = 1'b0;
    for (int k = 0; k < nb; k++) begin
      chk("rd_done_early", {127'd0, rsp_rd_done}, 128'd0);
      bus.M_AXI_RVALID = 1'b1;
      bus.M_AXI_RDATA  = d0 * 32'(k + 1);
      bus.M_AXI_RLAST  = (k == rlast_at);
      bus.M_AXI_RRESP  = (k == err_at) ? 2'b10 : 2'b00;
      tick();
    end
    bus.M_AXI_RVALID = 1'b0;
    bus.M_AXI_RLAST  = 1'b0;
    bus.M_AXI_RRESP  = 2'b00;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_rw = 1'b0; req_addr = 32'd0; req_wdata = 128'd0;
`ifdef AXI_M_WSTRB_EN
    req_wstrb = 16'h00F0;
`endif
    bus.M_AXI_AWREADY = 1'b0; bus.M_AXI_WREADY = 1'b0;
    bus.M_AXI_BVALID = 1'b0;  bus.M_AXI_BRESP = 2'b00;
    bus.M_AXI_ARREADY = 1'b0; bus.M_AXI_RVALID = 1'b0;
    bus.M_AXI_RDATA = 32'd0;  bus.M_AXI_RRESP = 2'b00; bus.M_AXI_RLAST = 1'b0;
    tick();
    tick();
    chk("rst_arvalid", bus.M_AXI_ARVALID, 1'b0);
    chk("rst_awvalid", bus.M_AXI_AWVALID, 1'b0);
    chk("rst_rdata", rsp_rdata, 128'd0);
    chk("rst_done", {rsp_rd_done, rsp_wr_done, rsp_err}, 3'b000);
    rst_n = 1'b1;
    tick();
    chk("ready_after_rst", req_ready, 1'b1);

    // Read of an unaligned address, ARREADY stalled one cycle
    send_req(1'b1, 32'h1000_0004, 128'd0);
    chk("ar_valid", bus.M_AXI_ARVALID, 1'b1);
    chk("ar_addr", bus.M_AXI_ARADDR, 32'h1000_0000);
    chk("ar_len_size_burst", {bus.M_AXI_ARLEN, bus.M_AXI_ARSIZE, bus.M_AXI_ARBURST}, {4'd3, 3'd2, 2'b01});
    chk("busy_not_ready", req_ready, 1'b0);
    tick();
    chk("ar_held", {bus.M_AXI_ARVALID, bus.M_AXI_ARADDR}, {1'b1, 32'h1000_0000});
    rd_burst(32'h11, 3, -1);
    chk("rd1_done", {rsp_rd_done, rsp_err, req_ready}, 3'b101);
    chk("rd1_data", rsp_rdata, 128'h00000044_00000033_00000022_00000011);
    chk("rd1_rready_off", bus.M_AXI_RREADY, 1'b0);
    tick();
    chk("rd1_single_pulse", rsp_rd_done, 1'b0);

    // Write with WREADY toggling every cycle
    send_req(1'b0, 32'h2000_001C, 128'hAABBCCDD_11223344_55667788_99AABBCC);
    chk("aw_valid", bus.M_AXI_AWVALID, 1'b1);
    chk("aw_addr", bus.M_AXI_AWADDR, 32'h2000_0010);
    chk("aw_len_size_burst", {bus.M_AXI_AWLEN, bus.M_AXI_AWSIZE, bus.M_AXI_AWBURST}, {4'd3, 3'd2, 2'b01});
    bus.M_AXI_AWREADY = 1'b1;
    tick();
    bus.M_AXI_AWREADY = 1'b0;
    chk("aw_dropped", bus.M_AXI_AWVALID, 1'b0);
    idx = 0;
    for (int c = 0; c < 20 && idx < 4; c++) begin
      bus.M_AXI_WREADY = c[0];
      chk("wvalid_held", bus.M_AXI_WVALID, 1'b1);
      if (bus.M_AXI_WREADY) begin
        chk("wdata", bus.M_AXI_WDATA, exp_w[idx]);
        chk("wlast", bus.M_AXI_WLAST, (idx == 3));
        chk("wstrb", bus.M_AXI_WSTRB, exp_s[idx]);
        idx++;
      end
      tick();
    end
    bus.M_AXI_WREADY = 1'b0;
    chk("w_beat_count", idx, 4);
    chk("w_done_bready", {bus.M_AXI_WVALID, bus.M_AXI_BREADY}, 2'b01);
    tick();
    chk("wr_wait_b", rsp_wr_done, 1'b0);
    bus.M_AXI_BVALID = 1'b1;
    tick();
    bus.M_AXI_BVALID = 1'b0;
    chk("wr1_done", {rsp_wr_done, rsp_err, req_ready, bus.M_AXI_BREADY}, 4'b1010);
    chk("rdata_kept_on_write", rsp_rdata, 128'h00000044_00000033_00000022_00000011);
    tick();
    chk("wr1_single_pulse", rsp_wr_done, 1'b0);

    // Write answered with SLVERR; a read is presented in the done cycle
    send_req(1'b0, 32'h3000_0000, 128'd0);
    bus.M_AXI_AWREADY = 1'b1;
    tick();
    bus.M_AXI_AWREADY = 1'b0;
    bus.M_AXI_WREADY = 1'b1;
    repeat (4) tick();
    bus.M_AXI_WREADY = 1'b0;
    bus.M_AXI_BVALID = 1'b1;
    bus.M_AXI_BRESP  = 2'b10;
    tick();
    bus.M_AXI_BVALID = 1'b0;
    bus.M_AXI_BRESP  = 2'b00;
    chk("wr_err_done", {rsp_wr_done, rsp_err, req_ready}, 3'b111);
    send_req(1'b1, 32'h4000_0000, 128'd0);
    chk("accept_in_done_cycle", {bus.M_AXI_ARVALID, bus.M_AXI_ARADDR}, {1'b1, 32'h4000_0000});
    chk("wr_err_pulse_over", {rsp_wr_done, rsp_err}, 2'b00);

    // Early RLAST on beat 1
    rd_burst(32'hA0, 1, -1);
    chk("early_rlast_done", {rsp_rd_done, rsp_err, req_ready}, 3'b111);
    chk("early_rlast_data", rsp_rdata, 128'h00000044_00000033_00000140_000000A0);

    // Reset in the middle of a read
    tick();
    send_req(1'b1, 32'h5000_0000, 128'd0);
    bus.M_AXI_ARREADY = 1'b1;
    tick();
    bus.M_AXI_ARREADY = 1'b0;
    bus.M_AXI_RVALID = 1'b1;
    bus.M_AXI_RDATA  = 32'h55;
    tick();
    bus.M_AXI_RDATA  = 32'h66;
    tick();
    bus.M_AXI_RVALID = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("mid_rst_ctrl", {req_ready, bus.M_AXI_RREADY, bus.M_AXI_ARVALID, rsp_rd_done, rsp_err}, 5'b10000);
    chk("mid_rst_rdata", rsp_rdata, 128'd0);
    chk("mid_rst_addr", bus.M_AXI_ARADDR, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_no_done", {rsp_rd_done, req_ready}, 2'b01);
    send_req(1'b1, 32'h6000_0008, 128'd0);
    chk("post_rst_ar_addr", bus.M_AXI_ARADDR, 32'h6000_0000);
    rd_burst(32'h1, 3, -1);
    chk("post_rst_rd_done", {rsp_rd_done, rsp_err}, 2'b10);
    chk("post_rst_rd_data", rsp_rdata, 128'h00000004_00000003_00000002_00000001);

    // RRESP error mid-burst, then a burst with RLAST missing
    send_req(1'b1, 32'h7000_0000, 128'd0);
    rd_burst(32'h2, 3, 2);
    chk("rresp_err", {rsp_rd_done, rsp_err}, 2'b11);
    chk("rresp_err_data", rsp_rdata, 128'h00000008_00000006_00000004_00000002);
    send_req(1'b1, 32'h7000_0040, 128'd0);
    rd_burst(32'h3, -1, -1);
    chk("missing_rlast", {rsp_rd_done, rsp_err}, 2'b11);
    chk("missing_rlast_data", rsp_rdata, 128'h0000000C_00000009_00000006_00000003);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
